// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-port serial link transmit side.
// Holds the transmitter state encoding, line-level constants and the
// frame-length helper used by anything that needs to reason about frame
// timing (start + address + data + stop).
package serial_link_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    localparam int   ADDR_W    = 2;
    localparam int   NUM_PORTS = 4;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Cycles occupied by one frame on the line, excluding the idle gap.
    function automatic int frame_len(input int data_w);
        return 3 + data_w + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter.
// The winner is the first asserted request searching upward from the port
// after the most recent winner (modulo 4). The pointer only moves when the
// caller accepts the current winner.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req_i       per-port request levels
//   accept_i    strobe: winner_o is being taken this cycle
//   winner_o    port number of the current winner (valid when valid_o)
//   valid_o     at least one request is asserted
module rr_arbiter4
    import serial_link_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 accept_i,
    output logic [ADDR_W-1:0]    winner_o,
    output logic                 valid_o
);

    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] idx;

    // Offset 4 wraps back to last_q itself, so a lone requester that just
    // won can still win again.
    always_comb begin
        winner_o = last_q;
        valid_o  = 1'b0;
        idx      = last_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = last_q + ADDR_W'(i);
            if (!valid_o && req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

    // Reset to port 3 so that port 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 2'd3;
        end else if (accept_i) begin
            last_q <= winner_o;
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Transmit-side scheduler for the 4-port serial link.
// Four requesters share one serial line. Frames are sent LSB first as
// START(0), addr[0], addr[1], d[0]..d[DATA_W-1], STOP(1), followed by GAP
// idle-high cycles. Arbitration happens in IDLE or on the last GAP cycle, so
// back-to-back frames have a pitch of 4+DATA_W+GAP cycles.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req          per-port request level, held until its grant pulses
//   data_in      payloads, port n at [n*DATA_W +: DATA_W]
//   grant        one-hot one-cycle pulse marking the captured port
//   serial_out   registered serial line, idles high
//   busy         high from START through the last GAP cycle
//   cur_port     port of the frame in flight, holds when idle
module serial_tx_arbiter
    import serial_link_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int GAP    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*DATA_W-1:0] data_in,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        serial_out,
    output logic                        busy,
    output logic [ADDR_W-1:0]           cur_port
);

    localparam int               CNT_W     = $clog2((DATA_W > 2) ? DATA_W : 2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(GAP - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             gap_q, gap_d;
    logic                   ser_q, ser_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]      cur_q, cur_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic                   arb_en;
    logic                   accept;
    logic [ADDR_W-1:0]      win;
    logic                   win_vld;

    rr_arbiter4 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .accept_i (accept),
        .winner_o (win),
        .valid_o  (win_vld)
    );

    // serial_out is registered, so each state loads the bit that the
    // *next* state puts on the line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ser_d   = ser_q;
        grant_d = '0;
        cur_d   = cur_q;
        sh_d    = sh_q;
        arb_en  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: arb_en = 1'b1;
            S_START: begin
                state_d = S_ADDR;
                ser_d   = cur_q[0];
                cnt_d   = '0;
            end
            S_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = S_DATA;
                    ser_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    cnt_d   = '0;
                end else begin
                    ser_d = cur_q[1];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = S_STOP;
                    ser_d   = STOP_BIT;
                    cnt_d   = '0;
                end else begin
                    ser_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                state_d = S_GAP;
                ser_d   = IDLE_LVL;
                gap_d   = '0;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    arb_en = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = IDLE_LVL;
            end
        endcase

        // Arbitration overrides the per-state defaults above.
        if (arb_en) begin
            gap_d = '0;
            if (win_vld) begin
                accept  = 1'b1;
                state_d = S_START;
                ser_d   = START_BIT;
                cur_d   = win;
                grant_d = NUM_PORTS'(1) << win;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (win == ADDR_W'(p)) begin
                        sh_d = data_in[p*DATA_W +: DATA_W];
                    end
                end
            end else begin
                state_d = S_IDLE;
                ser_d   = IDLE_LVL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ser_q   <= IDLE_LVL;
            grant_q <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ser_q   <= ser_d;
            grant_q <= grant_d;
            cur_q   <= cur_d;
        end
    end

    // Payload shift register carries data only; control state decides
    // whether its contents are ever used.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign grant      = grant_q;
    assign serial_out = ser_q;
    assign busy       = (state_q != S_IDLE);
    assign cur_port   = cur_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed testbench for serial_tx_arbiter: one default instance
// (DATA_W=4, GAP=1) and one wide instance (DATA_W=8, GAP=3).
module tb_serial_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, grant;
    logic [15:0] data_in;
    logic        serial_out, busy;
    logic [1:0]  cur_port;
    logic [3:0]  req8, grant8;
    logic [31:0] data_in8;
    logic        serial_out8, busy8;
    logic [1:0]  cur_port8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] auto_drop, auto_drop8;
    logic [3:0] lg_grant  [0:255];
    logic [3:0] lg_grant8 [0:255];
    logic       lg_ser    [0:255];
    logic       lg_ser8   [0:255];
    logic       lg_busy   [0:255];
    logic       lg_busy8  [0:255];
    logic [1:0] lg_cur    [0:255];
    int         nlog;
    int         ev_idx[$];
    logic [3:0] ev_val[$];

    always #5 clk = ~clk;

    serial_tx_arbiter #(.DATA_W(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .grant(grant), .serial_out(serial_out), .busy(busy), .cur_port(cur_port)
    );

    serial_tx_arbiter #(.DATA_W(8), .GAP(3)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .data_in(data_in8),
        .grant(grant8), .serial_out(serial_out8), .busy(busy8), .cur_port(cur_port8)
    );

    // Log n cycles of outputs at negedges; ports in auto_drop release req
    // once their grant is seen.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (nlog < 256) begin
                lg_grant[nlog]  = grant;
                lg_ser[nlog]    = serial_out;
                lg_busy[nlog]   = busy;
                lg_cur[nlog]    = cur_port;
                lg_grant8[nlog] = grant8;
                lg_ser8[nlog]   = serial_out8;
                lg_busy8[nlog]  = busy8;
            end
            nlog++;
            req  = req  & ~(grant  & auto_drop);
            req8 = req8 & ~(grant8 & auto_drop8);
        end
    endtask

    task automatic find_grants(input logic use8);
        logic [3:0] g;
        ev_idx.delete();
        ev_val.delete();
        for (int i = 0; i < nlog && i < 256; i++) begin
            g = use8 ? lg_grant8[i] : lg_grant[i];
            if (g != 4'b0) begin
                ev_idx.push_back(i);
                ev_val.push_back(g);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; req8 = '0; auto_drop = '0; auto_drop8 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nlog = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; req8 = 4'b1000;
        data_in = 16'h4321; data_in8 = 32'h0;
        auto_drop = '0; auto_drop8 = '0; nlog = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b expected 1", serial_out); end
        n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (cur_port !== 2'd0) begin n_fail++; $display("FAIL reset_cur_port: got %0d expected 0", cur_port); end
        n_checks++; if (serial_out8 !== 1'b1 || busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_wide: got ser=%b busy=%b expected 1/0", serial_out8, busy8); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_prio: got %b expected 0001", grant); end
        n_checks++; if (grant8 !== 4'b1000) begin n_fail++; $display("FAIL reset_wide_grant: got %b expected 1000", grant8); end
        @(negedge clk);
        n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL grant_pulse_width: got %b expected 0000", grant); end
    endtask

    task automatic test_single();
        logic [7:0] exp_bits;
        int nbusy;
        do_reset();
        data_in = {4'h0, 4'b1011, 4'h0, 4'h0};
        req = 4'b0100; auto_drop = 4'b0100;
        capture(12);
        exp_bits = 8'b1101_1100;
        n_checks++; if (lg_grant[0] !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", lg_grant[0]); end
        n_checks++; if (lg_grant[1] !== 4'b0000) begin n_fail++; $display("FAIL single_grant_drop: got %b expected 0000", lg_grant[1]); end
        n_checks++; if (lg_cur[0] !== 2'd2) begin n_fail++; $display("FAIL single_cur_port: got %0d expected 2", lg_cur[0]); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (lg_ser[i] !== exp_bits[i]) begin n_fail++; $display("FAIL single_bit%0d: got %b expected %b", i, lg_ser[i], exp_bits[i]); end
        end
        n_checks++; if (lg_ser[8] !== 1'b1 || lg_ser[9] !== 1'b1) begin n_fail++; $display("FAIL single_idle_after: got %b%b expected 11", lg_ser[8], lg_ser[9]); end
        nbusy = 0;
        for (int i = 0; i < 12; i++) if (lg_busy[i] === 1'b1) nbusy++;
        n_checks++; if (nbusy != 9 || lg_busy[8] !== 1'b1) begin n_fail++; $display("FAIL single_busy_len: got %0d cycles expected 9", nbusy); end
    endtask

    task automatic test_round_robin();
        int exp_p [5];
        logic [3:0] got;
        int i0;
        exp_p = '{0, 1, 2, 3, 0};
        do_reset();
        data_in = {4'hD, 4'hA, 4'h6, 4'h1};
        req = 4'b1111; auto_drop = 4'b0000;
        capture(45);
        find_grants(1'b0);
        n_checks++; if (ev_idx.size() != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", ev_idx.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < ev_idx.size()) begin
                i0 = ev_idx[k];
                got = {lg_ser[i0+6], lg_ser[i0+5], lg_ser[i0+4], lg_ser[i0+3]};
                n_checks++; if (i0 != 9*k) begin n_fail++; $display("FAIL rr_pitch%0d: got cycle %0d expected %0d", k, i0, 9*k); end
                n_checks++; if (ev_val[k] !== (4'b0001 << exp_p[k])) begin n_fail++; $display("FAIL rr_order%0d: got %b expected port %0d", k, ev_val[k], exp_p[k]); end
                n_checks++; if (lg_cur[i0] !== 2'(exp_p[k])) begin n_fail++; $display("FAIL rr_cur%0d: got %0d expected %0d", k, lg_cur[i0], exp_p[k]); end
                n_checks++; if (lg_ser[i0] !== 1'b0) begin n_fail++; $display("FAIL rr_start%0d: got %b expected 0", k, lg_ser[i0]); end
                n_checks++; if ({lg_ser[i0+2], lg_ser[i0+1]} !== 2'(exp_p[k])) begin n_fail++; $display("FAIL rr_addr%0d: got %b%b expected %0d", k, lg_ser[i0+2], lg_ser[i0+1], exp_p[k]); end
                n_checks++; if (got !== data_in[exp_p[k]*4 +: 4]) begin n_fail++; $display("FAIL rr_data%0d: got %h expected %h", k, got, data_in[exp_p[k]*4 +: 4]); end
                n_checks++; if (lg_ser[i0+7] !== 1'b1) begin n_fail++; $display("FAIL rr_stop%0d: got %b expected 1", k, lg_ser[i0+7]); end
            end
        end
    endtask

    task automatic test_fairness();
        int exp_i [5];
        logic [3:0] exp_g [5];
        exp_i = '{0, 9, 18, 27, 36};
        exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        data_in = 16'h4321;
        req = 4'b0010; auto_drop = 4'b1101;
        capture(8);
        n_checks++; if (lg_ser[7] !== 1'b1 || lg_busy[7] !== 1'b1) begin n_fail++; $display("FAIL fair_stop: got ser=%b busy=%b expected 1/1", lg_ser[7], lg_busy[7]); end
        req = 4'b1111;
        capture(37);
        find_grants(1'b0);
        n_checks++; if (ev_idx.size() != 5) begin n_fail++; $display("FAIL fair_grant_count: got %0d expected 5", ev_idx.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < ev_idx.size()) begin
                n_checks++; if (ev_idx[k] != exp_i[k] || ev_val[k] !== exp_g[k]) begin n_fail++; $display("FAIL fair_order%0d: got %b at %0d expected %b at %0d", k, ev_val[k], ev_idx[k], exp_g[k], exp_i[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_in = 16'h0000;
        req = 4'b0100; auto_drop = 4'b0100;
        capture(5);
        n_checks++; if (lg_ser[4] !== 1'b0 || lg_busy[4] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_data: got ser=%b busy=%b expected 0/1", lg_ser[4], lg_busy[4]); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL mid_async_serial: got %b expected 1", serial_out); end
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0) begin n_fail++; $display("FAIL mid_async_ctrl: got busy=%b grant=%b expected 0/0000", busy, grant); end
        n_checks++; if (cur_port !== 2'd0) begin n_fail++; $display("FAIL mid_async_cur: got %0d expected 0", cur_port); end
        req = 4'b1001;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0 || serial_out !== 1'b1) begin n_fail++; $display("FAIL mid_hold: got grant=%b ser=%b expected 0000/1", grant, serial_out); end
        rst = 1'b0; nlog = 0; auto_drop = 4'b1001;
        capture(2);
        n_checks++; if (lg_grant[0] !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_prio: got %b expected 0001", lg_grant[0]); end
        n_checks++; if (lg_cur[0] !== 2'd0 || lg_ser[0] !== 1'b0) begin n_fail++; $display("FAIL mid_restart_frame: got cur=%0d ser=%b expected 0/0", lg_cur[0], lg_ser[0]); end
        n_checks++; if (lg_grant[1] !== 4'b0) begin n_fail++; $display("FAIL mid_no_regrant: got %b expected 0000", lg_grant[1]); end
    endtask

    task automatic test_gap_wide();
        logic [7:0] got8;
        int bad;
        do_reset();
        data_in8 = {8'hA5, 24'h0};
        req8 = 4'b1000; auto_drop8 = 4'b0000;
        capture(32);
        for (int j = 0; j < 8; j++) got8[j] = lg_ser8[3+j];
        n_checks++; if (lg_grant8[0] !== 4'b1000 || lg_ser8[0] !== 1'b0) begin n_fail++; $display("FAIL wide_start: got grant=%b ser=%b expected 1000/0", lg_grant8[0], lg_ser8[0]); end
        n_checks++; if (lg_ser8[1] !== 1'b1 || lg_ser8[2] !== 1'b1) begin n_fail++; $display("FAIL wide_addr: got %b%b expected 11", lg_ser8[1], lg_ser8[2]); end
        n_checks++; if (got8 !== 8'hA5) begin n_fail++; $display("FAIL wide_data: got %h expected a5", got8); end
        n_checks++; if (lg_ser8[11] !== 1'b1) begin n_fail++; $display("FAIL wide_stop: got %b expected 1", lg_ser8[11]); end
        bad = 0;
        for (int j = 12; j < 15; j++) if (lg_ser8[j] !== 1'b1 || lg_busy8[j] !== 1'b1) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wide_gap_idle: got %0d bad gap cycles expected 0", bad); end
        bad = 0;
        for (int j = 0; j < 15; j++) if (lg_busy8[j] !== 1'b1) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wide_busy: got %0d low cycles expected 0", bad); end
        n_checks++; if (lg_grant8[15] !== 4'b1000 || lg_ser8[15] !== 1'b0) begin n_fail++; $display("FAIL wide_pitch: got grant=%b ser=%b at 15 expected 1000/0", lg_grant8[15], lg_ser8[15]); end
        find_grants(1'b1);
        n_checks++; if (ev_idx.size() != 3) begin n_fail++; $display("FAIL wide_grant_count: got %0d expected 3", ev_idx.size()); end
    endtask

    task automatic test_pulse();
        int bad;
        do_reset();
        data_in = 16'h0F00;
        req = 4'b0100; auto_drop = 4'b0100;
        capture(3);
        req[0] = 1'b1;
        capture(1);
        req[0] = 1'b0;
        capture(20);
        find_grants(1'b0);
        n_checks++; if (ev_idx.size() != 1) begin n_fail++; $display("FAIL pulse_grant_count: got %0d expected 1", ev_idx.size()); end
        bad = 0;
        for (int j = 7; j < 24; j++) if (lg_ser[j] !== 1'b1) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pulse_line_idle: got %0d low cycles expected 0", bad); end
        bad = 0;
        for (int j = 9; j < 24; j++) if (lg_busy[j] !== 1'b0) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pulse_busy_idle: got %0d busy cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid();
        test_gap_wide();
        test_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
